// File: rtl/mcu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : mcu_pkg                                                           |
// | Brief  : Opcodes, FSM state encoding and instruction field positions.      |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
package mcu_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_MOV  = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_XOR  = 4'h7;
    localparam logic [3:0] OP_IN   = 4'h8;
    localparam logic [3:0] OP_OUT  = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_JZ   = 4'hB;
    localparam logic [3:0] OP_JC   = 4'hC;
    localparam logic [3:0] OP_SIE  = 4'hD;
    localparam logic [3:0] OP_RETI = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [2:0] ST_FETCH   = 3'd0;
    localparam logic [2:0] ST_DECODE  = 3'd1;
    localparam logic [2:0] ST_EXEC    = 3'd2;
    localparam logic [2:0] ST_IO_WAIT = 3'd3;
    localparam logic [2:0] ST_HALT    = 3'd4;

    localparam int IR_OP_LSB  = 12;
    localparam int IR_RD_LSB  = 10;
    localparam int IR_RS_LSB  = 8;
    localparam int IR_IMM_LSB = 0;

endpackage
`default_nettype wire

// File: rtl/mcu_alu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : mcu_alu                                                           |
// | Brief  : Combinational ALU for ADD/SUB/AND/OR/XOR with zero/carry flags.   |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module mcu_alu
    import mcu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [3:0]        op,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              carry
);

    logic [DATA_W:0] w_ext;

    // Extra top bit holds ADD carry-out, or SUB borrow (set when b > a).
    always_comb begin
        w_ext = '0;
        carry = 1'b0;
        case (op)
            OP_ADD: begin
                w_ext = {1'b0, a} + {1'b0, b};
                carry = w_ext[DATA_W];
            end
            OP_SUB: begin
                w_ext = {1'b0, a} - {1'b0, b};
                carry = w_ext[DATA_W];
            end
            OP_AND:  w_ext = {1'b0, a & b};
            OP_OR:   w_ext = {1'b0, a | b};
            OP_XOR:  w_ext = {1'b0, a ^ b};
            default: w_ext = '0;
        endcase
    end

    assign result = w_ext[DATA_W-1:0];
    assign zero   = (result == '0);

endmodule
`default_nettype wire

// File: rtl/mcu_core_p.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : mcu_core_p                                                        |
// | Brief  : Multi-cycle MCU core with handshaked IO, one interrupt and HALT.  |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module mcu_core_p
    import mcu_pkg::*;
#(
    parameter int         DATA_W   = 8,
    parameter int         PC_W     = 8,
    parameter int         IO_PORTS = 2,
    parameter logic [7:0] IRQ_VEC  = 8'hF0
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic [PC_W-1:0]              imem_addr,
    input  logic [15:0]                  imem_data,
    input  logic [IO_PORTS*DATA_W-1:0]   io_in_data,
    input  logic [IO_PORTS-1:0]          io_in_valid,
    output logic [IO_PORTS-1:0]          io_in_ack,
    output logic [DATA_W-1:0]            io_out_data,
    output logic [2:0]                   io_out_sel,
    output logic                         io_out_valid,
    input  logic                         io_out_ready,
    input  logic                         irq,
    output logic [PC_W-1:0]              pc_out,
    output logic                         zero,
    output logic                         carry,
    output logic                         halted
);

    logic [2:0]        r_state;
    logic [PC_W-1:0]   r_pc;
    logic [PC_W-1:0]   r_epc;
    logic [15:0]       r_ir;
    logic [DATA_W-1:0] r_regs [4];
    logic              r_zero, r_carry, r_ezero, r_ecarry, r_ie;
    logic [DATA_W-1:0] r_out_data;
    logic [2:0]        r_out_sel;
    logic              r_out_valid;
    logic              r_halted;

    logic [3:0]        w_op;
    logic [1:0]        w_rd, w_rs;
    logic [7:0]        w_imm;
    logic [PC_W-1:0]   w_imm_pc;
    logic [2:0]        w_ch;
    logic              w_in_valid;
    logic [DATA_W-1:0] w_in_data;
    logic              w_in_fire;
    logic              w_irq_take;
    logic [DATA_W-1:0] w_alu_res;
    logic              w_alu_zero, w_alu_carry;

    assign w_op       = r_ir[IR_OP_LSB +: 4];
    assign w_rd       = r_ir[IR_RD_LSB +: 2];
    assign w_rs       = r_ir[IR_RS_LSB +: 2];
    assign w_imm      = r_ir[IR_IMM_LSB +: 8];
    assign w_imm_pc   = PC_W'(w_imm);
    assign w_ch       = 3'({29'd0, w_imm[2:0]} % IO_PORTS);
    assign w_irq_take = irq && r_ie;
    assign w_in_fire  = (r_state == ST_IO_WAIT) && (w_op == OP_IN) && w_in_valid;

    // Channel mux and ack decode; the ack is the same cycle the data is taken.
    always_comb begin
        w_in_valid = 1'b0;
        w_in_data  = '0;
        io_in_ack  = '0;
        for (int k = 0; k < IO_PORTS; k++) begin
            if (w_ch == 3'(k)) begin
                w_in_valid   = io_in_valid[k];
                w_in_data    = io_in_data[k*DATA_W +: DATA_W];
                io_in_ack[k] = w_in_fire;
            end
        end
    end

    mcu_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a      (r_regs[w_rd]),
        .b      (r_regs[w_rs]),
        .op     (w_op),
        .result (w_alu_res),
        .zero   (w_alu_zero),
        .carry  (w_alu_carry)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_FETCH;
            r_pc        <= '0;
            r_epc       <= '0;
            r_ir        <= '0;
            for (int i = 0; i < 4; i++) r_regs[i] <= '0;
            r_zero      <= 1'b0;
            r_carry     <= 1'b0;
            r_ezero     <= 1'b0;
            r_ecarry    <= 1'b0;
            r_ie        <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_out_valid <= 1'b0;
            r_halted    <= 1'b0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    // Vectoring spends this FETCH cycle; the handler is fetched next.
                    if (w_irq_take) begin
                        r_epc    <= r_pc;
                        r_ezero  <= r_zero;
                        r_ecarry <= r_carry;
                        r_ie     <= 1'b0;
                        r_pc     <= PC_W'(IRQ_VEC);
                    end else begin
                        r_state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    r_ir    <= imem_data;
                    r_pc    <= r_pc + PC_W'(1);
                    r_state <= ST_EXEC;
                end
                ST_EXEC: begin
                    r_state <= ST_FETCH;
                    case (w_op)
                        OP_NOP: ;
                        OP_LDI: r_regs[w_rd] <= DATA_W'(w_imm);
                        OP_MOV: r_regs[w_rd] <= r_regs[w_rs];
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                            r_regs[w_rd] <= w_alu_res;
                            r_zero       <= w_alu_zero;
                            r_carry      <= w_alu_carry;
                        end
                        OP_IN:  r_state <= ST_IO_WAIT;
                        OP_OUT: begin
                            r_out_data  <= r_regs[w_rd];
                            r_out_sel   <= w_ch;
                            r_out_valid <= 1'b1;
                            r_state     <= ST_IO_WAIT;
                        end
                        OP_JMP: r_pc <= w_imm_pc;
                        OP_JZ:  if (r_zero)  r_pc <= w_imm_pc;
                        OP_JC:  if (r_carry) r_pc <= w_imm_pc;
                        OP_SIE: r_ie <= w_imm[0];
                        OP_RETI: begin
                            r_pc    <= r_epc;
                            r_zero  <= r_ezero;
                            r_carry <= r_ecarry;
                            r_ie    <= 1'b1;
                        end
                        OP_HALT: begin
                            r_state  <= ST_HALT;
                            r_halted <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                ST_IO_WAIT: begin
                    if (w_op == OP_IN) begin
                        if (w_in_valid) begin
                            r_regs[w_rd] <= w_in_data;
                            r_state      <= ST_FETCH;
                        end
                    end else if (io_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_FETCH;
                    end
                end
                ST_HALT: begin
                    if (w_irq_take) begin
                        r_epc    <= r_pc;
                        r_ezero  <= r_zero;
                        r_ecarry <= r_carry;
                        r_ie     <= 1'b0;
                        r_pc     <= PC_W'(IRQ_VEC);
                        r_halted <= 1'b0;
                        r_state  <= ST_FETCH;
                    end
                end
                default: r_state <= ST_FETCH;
            endcase
        end
    end

    assign imem_addr    = r_pc;
    assign pc_out       = r_pc;
    assign zero         = r_zero;
    assign carry        = r_carry;
    assign halted       = r_halted;
    assign io_out_data  = r_out_data;
    assign io_out_sel   = r_out_sel;
    assign io_out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_mcu_core_p.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_mcu_core_p                                                     |
// | Brief  : Directed scenarios plus random programs against an ISA model.     |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_mcu_core_p;

    localparam logic [3:0] I_NOP = 4'h0, I_LDI = 4'h1, I_ADD = 4'h3, I_SUB = 4'h4;
    localparam logic [3:0] I_IN = 4'h8, I_OUT = 4'h9, I_JC = 4'hC, I_SIE = 4'hD;
    localparam logic [3:0] I_RETI = 4'hE, I_HALT = 4'hF;

    logic        clk, reset;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data;
    logic [15:0] io_in_data;
    logic [1:0]  io_in_valid, io_in_ack;
    logic [7:0]  io_out_data;
    logic [2:0]  io_out_sel;
    logic        io_out_valid, io_out_ready, irq;
    logic [7:0]  pc_out;
    logic        zero, carry, halted;

    logic [15:0] rom [256];
    int n_vec = 0;
    int n_err = 0;

    mcu_core_p #(.DATA_W(8), .PC_W(8), .IO_PORTS(2), .IRQ_VEC(8'hF0)) dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
        .io_in_data(io_in_data), .io_in_valid(io_in_valid), .io_in_ack(io_in_ack),
        .io_out_data(io_out_data), .io_out_sel(io_out_sel), .io_out_valid(io_out_valid),
        .io_out_ready(io_out_ready), .irq(irq), .pc_out(pc_out), .zero(zero),
        .carry(carry), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM: one cycle of read latency.
    always @(posedge clk) imem_data <= rom[imem_addr];

    function automatic logic [15:0] enc(input logic [3:0] op, input logic [1:0] rd,
                                        input logic [1:0] rs, input logic [7:0] imm);
        return {op, rd, rs, imm};
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = enc(I_NOP, 2'd0, 2'd0, 8'h00);
    endtask

    task automatic start();
        reset = 1'b1; io_in_valid = '0; io_in_data = '0; io_out_ready = 1'b0; irq = 1'b0;
        step(2);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        clear_rom();
        rom[0] = enc(I_LDI, 2'd0, 2'd0, 8'hA5);
        rom[1] = enc(I_OUT, 2'd0, 2'd0, 8'h01);
        start();
        step(6);
        n_vec++; if (io_out_valid !== 1'b1) begin n_err++; $display("FAIL rst_pre_valid got %b exp 1", io_out_valid); end
        n_vec++; if (io_out_data !== 8'hA5) begin n_err++; $display("FAIL rst_pre_data got %h exp a5", io_out_data); end
        step(2);
        reset = 1'b1;
        step(1);
        n_vec++; if (io_out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b exp 0", io_out_valid); end
        n_vec++; if (io_out_data !== 8'h00) begin n_err++; $display("FAIL rst_data got %h exp 00", io_out_data); end
        n_vec++; if (io_out_sel !== 3'd0) begin n_err++; $display("FAIL rst_sel got %0d exp 0", io_out_sel); end
        n_vec++; if (pc_out !== 8'h00) begin n_err++; $display("FAIL rst_pc got %h exp 00", pc_out); end
        n_vec++; if (imem_addr !== 8'h00) begin n_err++; $display("FAIL rst_imem_addr got %h exp 00", imem_addr); end
        n_vec++; if (io_in_ack !== 2'b00) begin n_err++; $display("FAIL rst_ack got %b exp 00", io_in_ack); end
        n_vec++; if ({zero, carry, halted} !== 3'b000) begin n_err++; $display("FAIL rst_flags got %b exp 000", {zero, carry, halted}); end
        reset = 1'b0;
        step(3);
        n_vec++; if (pc_out !== 8'h01) begin n_err++; $display("FAIL rst_restart_pc got %h exp 01", pc_out); end
    endtask

    task automatic test_add_carry();
        clear_rom();
        rom[0] = enc(I_LDI, 2'd0, 2'd0, 8'hFF);
        rom[1] = enc(I_LDI, 2'd1, 2'd0, 8'h01);
        rom[2] = enc(I_ADD, 2'd0, 2'd1, 8'h00);
        rom[3] = enc(I_OUT, 2'd0, 2'd0, 8'h00);
        start();
        step(3);
        n_vec++; if (pc_out !== 8'h01) begin n_err++; $display("FAIL add_pc1 got %h exp 01", pc_out); end
        step(3);
        n_vec++; if (pc_out !== 8'h02) begin n_err++; $display("FAIL add_pc2 got %h exp 02", pc_out); end
        step(2);
        n_vec++; if ({zero, carry} !== 2'b00) begin n_err++; $display("FAIL add_early_flags got %b exp 00", {zero, carry}); end
        step(1);
        n_vec++; if (pc_out !== 8'h03) begin n_err++; $display("FAIL add_pc3 got %h exp 03", pc_out); end
        n_vec++; if ({zero, carry} !== 2'b11) begin n_err++; $display("FAIL add_flags got %b exp 11", {zero, carry}); end
        step(3);
        n_vec++; if (io_out_valid !== 1'b1 || io_out_data !== 8'h00) begin n_err++; $display("FAIL add_r0 got v=%b d=%h exp v=1 d=00", io_out_valid, io_out_data); end
        io_out_ready = 1'b1;
        step(1);
        io_out_ready = 1'b0;
        n_vec++; if (io_out_valid !== 1'b0) begin n_err++; $display("FAIL add_out_drop got %b exp 0", io_out_valid); end
    endtask

    task automatic test_sub_jc();
        clear_rom();
        rom[0] = enc(I_LDI, 2'd0, 2'd0, 8'h03);
        rom[1] = enc(I_LDI, 2'd1, 2'd0, 8'h05);
        rom[2] = enc(I_SUB, 2'd0, 2'd1, 8'h00);
        rom[3] = enc(I_JC, 2'd0, 2'd0, 8'h20);
        rom[8'h20] = enc(I_OUT, 2'd0, 2'd0, 8'h00);
        start();
        step(9);
        n_vec++; if ({zero, carry} !== 2'b01) begin n_err++; $display("FAIL sub_flags got %b exp 01", {zero, carry}); end
        step(3);
        n_vec++; if (pc_out !== 8'h20) begin n_err++; $display("FAIL jc_pc got %h exp 20", pc_out); end
        step(3);
        n_vec++; if (io_out_data !== 8'hFE) begin n_err++; $display("FAIL sub_r0 got %h exp fe", io_out_data); end
        io_out_ready = 1'b1;
        step(1);
        io_out_ready = 1'b0;
    endtask

    task automatic test_in_stall();
        logic [7:0] d;
        d = 8'($urandom);
        clear_rom();
        rom[0] = enc(I_IN, 2'd2, 2'd0, 8'h03);   // channel 3 mod 2 = 1
        rom[1] = enc(I_OUT, 2'd2, 2'd0, 8'h00);
        start();
        io_in_data = {d, ~d};
        io_in_valid = 2'b01;
        step(3);
        for (int i = 0; i < 4; i++) begin
            n_vec++; if (io_in_ack !== 2'b00 || pc_out !== 8'h01) begin n_err++; $display("FAIL in_stall got ack=%b pc=%h exp ack=00 pc=01", io_in_ack, pc_out); end
            step(1);
        end
        io_in_valid = 2'b11;
        #1;
        n_vec++; if (io_in_ack !== 2'b10) begin n_err++; $display("FAIL in_ack got %b exp 10", io_in_ack); end
        step(1);
        #1;
        n_vec++; if (io_in_ack !== 2'b00) begin n_err++; $display("FAIL in_ack_once got %b exp 00", io_in_ack); end
        io_in_valid = 2'b00;
        step(3);
        n_vec++; if (io_out_valid !== 1'b1 || io_out_data !== d) begin n_err++; $display("FAIL in_r2 got v=%b d=%h exp v=1 d=%h", io_out_valid, io_out_data, d); end
        io_out_ready = 1'b1;
        step(1);
        io_out_ready = 1'b0;
    endtask

    task automatic test_out_stall();
        logic [7:0] d;
        d = 8'($urandom);
        clear_rom();
        rom[0] = enc(I_LDI, 2'd0, 2'd0, d);
        rom[1] = enc(I_OUT, 2'd0, 2'd0, 8'h05);  // channel 5 mod 2 = 1
        start();
        step(6);
        for (int i = 0; i < 6; i++) begin
            n_vec++; if (io_out_valid !== 1'b1 || io_out_data !== d || io_out_sel !== 3'd1) begin n_err++; $display("FAIL out_hold got v=%b d=%h s=%0d exp v=1 d=%h s=1", io_out_valid, io_out_data, io_out_sel, d); end
            if (i < 5) step(1);
        end
        io_out_ready = 1'b1;
        step(1);
        io_out_ready = 1'b0;
        n_vec++; if (io_out_valid !== 1'b0 || pc_out !== 8'h02) begin n_err++; $display("FAIL out_done got v=%b pc=%h exp v=0 pc=02", io_out_valid, pc_out); end
    endtask

    task automatic test_irq();
        clear_rom();
        rom[0] = enc(I_SIE, 2'd0, 2'd0, 8'h01);
        rom[1] = enc(I_LDI, 2'd0, 2'd0, 8'hFF);
        rom[2] = enc(I_LDI, 2'd1, 2'd0, 8'h01);
        rom[3] = enc(I_ADD, 2'd0, 2'd1, 8'h00);
        rom[4] = enc(I_HALT, 2'd0, 2'd0, 8'h00);
        rom[8'hF0] = enc(I_LDI, 2'd2, 2'd0, 8'h01);
        rom[8'hF1] = enc(I_ADD, 2'd2, 2'd2, 8'h00);
        rom[8'hF2] = enc(I_RETI, 2'd0, 2'd0, 8'h00);
        start();
        step(10);
        irq = 1'b1;
        step(2);
        n_vec++; if (pc_out !== 8'h04 || {zero, carry} !== 2'b11) begin n_err++; $display("FAIL irq_add_done got pc=%h zc=%b exp pc=04 zc=11", pc_out, {zero, carry}); end
        step(1);
        n_vec++; if (pc_out !== 8'hF0) begin n_err++; $display("FAIL irq_vector got %h exp f0", pc_out); end
        step(3);
        n_vec++; if (pc_out !== 8'hF1) begin n_err++; $display("FAIL irq_masked got %h exp f1", pc_out); end
        irq = 1'b0;
        step(3);
        n_vec++; if ({zero, carry} !== 2'b00) begin n_err++; $display("FAIL irq_handler_flags got %b exp 00", {zero, carry}); end
        step(3);
        n_vec++; if (pc_out !== 8'h04 || {zero, carry} !== 2'b11) begin n_err++; $display("FAIL reti got pc=%h zc=%b exp pc=04 zc=11", pc_out, {zero, carry}); end
        step(3);
        n_vec++; if (halted !== 1'b1 || pc_out !== 8'h05) begin n_err++; $display("FAIL halt got h=%b pc=%h exp h=1 pc=05", halted, pc_out); end
        step(3);
        n_vec++; if (halted !== 1'b1 || pc_out !== 8'h05) begin n_err++; $display("FAIL halt_stay got h=%b pc=%h exp h=1 pc=05", halted, pc_out); end
        irq = 1'b1;
        step(1);
        irq = 1'b0;
        n_vec++; if (halted !== 1'b0 || pc_out !== 8'hF0) begin n_err++; $display("FAIL halt_wake got h=%b pc=%h exp h=0 pc=f0", halted, pc_out); end
    endtask

    // Random straight-line programs; expected state comes from an ISA-level model.
    task automatic test_random();
        int m_r [4];
        int mz, mc, a, b, res, op, rd, rs, imm, ch;
        for (int t = 0; t < 15; t++) begin
            int ops [10], rds [10], rss [10], imms [10], chs [4];
            clear_rom();
            for (int i = 0; i < 10; i++) begin
                ops[i] = $urandom_range(0, 7); rds[i] = $urandom_range(0, 3);
                rss[i] = $urandom_range(0, 3); imms[i] = $urandom_range(0, 255);
                rom[i] = enc(4'(ops[i]), 2'(rds[i]), 2'(rss[i]), 8'(imms[i]));
            end
            for (int j = 0; j < 4; j++) begin
                chs[j] = $urandom_range(0, 7);
                rom[10 + j] = enc(I_OUT, 2'(j), 2'd0, 8'(chs[j]));
            end
            for (int k = 0; k < 4; k++) m_r[k] = 0;
            mz = 0; mc = 0;
            start();
            for (int i = 0; i < 10; i++) begin
                op = ops[i]; rd = rds[i]; rs = rss[i]; imm = imms[i];
                a = m_r[rd]; b = m_r[rs]; res = 0;
                case (op)
                    1: m_r[rd] = imm;
                    2: m_r[rd] = b;
                    3: begin res = (a + b) % 256; mc = (a + b > 255) ? 1 : 0; end
                    4: begin res = (a - b + 256) % 256; mc = (b > a) ? 1 : 0; end
                    5: begin res = a & b; mc = 0; end
                    6: begin res = a | b; mc = 0; end
                    7: begin res = a ^ b; mc = 0; end
                    default: ;
                endcase
                if (op >= 3) begin m_r[rd] = res; mz = (res == 0) ? 1 : 0; end
                step(3);
                n_vec++; if (zero !== 1'(mz) || carry !== 1'(mc) || pc_out !== 8'(i + 1)) begin n_err++; $display("FAIL rnd_step t=%0d i=%0d op=%0d got z=%b c=%b pc=%h exp z=%0d c=%0d pc=%0d", t, i, op, zero, carry, pc_out, mz, mc, i + 1); end
            end
            for (int j = 0; j < 4; j++) begin
                step(3);
                ch = chs[j] % 2;
                n_vec++; if (io_out_valid !== 1'b1 || io_out_data !== 8'(m_r[j]) || io_out_sel !== 3'(ch)) begin n_err++; $display("FAIL rnd_out t=%0d r%0d got v=%b d=%h s=%0d exp v=1 d=%h s=%0d", t, j, io_out_valid, io_out_data, io_out_sel, 8'(m_r[j]), ch); end
                step($urandom_range(0, 2));
                io_out_ready = 1'b1;
                step(1);
                io_out_ready = 1'b0;
                n_vec++; if (io_out_valid !== 1'b0) begin n_err++; $display("FAIL rnd_out_drop t=%0d r%0d got %b exp 0", t, j, io_out_valid); end
            end
        end
    endtask

    initial begin
        reset = 1'b1; irq = 1'b0; io_in_valid = '0; io_in_data = '0; io_out_ready = 1'b0;
        clear_rom();
        test_reset();
        test_add_carry();
        test_sub_jc();
        test_in_stall();
        test_out_stall();
        test_irq();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
